// File: rtl/cmd_port_queue.sv
// cmd_port_queue: framed command-byte parser with destination filtering,
// SPI-flash opcode decode, a DEPTH-entry command FIFO and single-issue
// tracking toward the Transaction FSM with a done acknowledgement.
// Optional feature macro: CMDP_NACK_EN -- when defined, an invalid opcode
// addressed to MY_ID is answered with ack_valid=1, ack_ok=0.
module cmd_port_queue #(
    parameter logic [3:0] MY_ID  = 4'h2,
    parameter int         ADDR_W = 24,
    parameter int         DEPTH  = 4,
    parameter int         LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_valid,
    input  logic [7:0]        bus_data,
    output logic              bus_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [3:0]        fsm_opcode,
    output logic              read_write,
    output logic [LEN_W-1:0]  transaction_length,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              transaction_done,
    output logic              ack_valid,
    output logic              ack_ok
);
    localparam int ADDR_BYTES = ADDR_W / 8;
    localparam int PW         = $clog2(DEPTH);
    localparam int CNT_W      = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [3:0] OPC_INVALID = 4'hF;

    typedef enum logic [1:0] {S_HDR, S_OPC, S_ADDR, S_PUSH} state_t;

    typedef struct packed {
        logic [3:0]        opc;
        logic              rw;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    state_t            state, state_n;
    logic              match_q;
    logic [LEN_W-1:0]  len_q;
    logic [3:0]        opc_q;
    logic              rw_q;
    logic              bad_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              addr_last;
    logic              push;
    logic              pop;
    logic              busy;
    logic              nack_pend;
    logic              empty;
    logic              full;
    logic [PW:0]       wr_ptr, rd_ptr;
    entry_t            mem [DEPTH];
    entry_t            head;
    logic [3:0]        dec;

    function automatic logic [3:0] decode(input logic [7:0] op);
        case (op)
            8'h02:   return 4'd0;
            8'h03:   return 4'd1;
            8'h20:   return 4'd2;
            8'h52:   return 4'd3;
            8'hD8:   return 4'd4;
            8'h99:   return 4'd5;
            default: return OPC_INVALID;
        endcase
    endfunction

    assign dec       = decode(bus_data);
    assign addr_last = (cnt_q == CNT_LAST);

    // Parser state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_HDR;
        else     state <= state_n;
    end

    // Parser next-state, bus_ready and FIFO write strobe
    always_comb begin
        state_n   = state;
        bus_ready = 1'b0;
        push      = 1'b0;
        case (state)
            S_HDR: begin
                bus_ready = 1'b1;
                if (bus_valid) state_n = S_OPC;
            end
            S_OPC: begin
                bus_ready = 1'b1;
                if (bus_valid) state_n = S_ADDR;
            end
            S_ADDR: begin
                bus_ready = 1'b1;
                if (bus_valid && addr_last) begin
                    if (!match_q)
                        state_n = S_HDR;
                    else if (bad_q)
`ifdef CMDP_NACK_EN
                        state_n = S_PUSH;   // park here until the nack is out
`else
                        state_n = S_HDR;    // silently dropped
`endif
                    else
                        state_n = S_PUSH;
                end
            end
            S_PUSH: begin
                if (bad_q) begin
                    if (!nack_pend) state_n = S_HDR;
                end else if (!full) begin
                    push    = 1'b1;
                    state_n = S_HDR;
                end
            end
            default: state_n = S_HDR;
        endcase
    end

    // Frame field capture as bytes are accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
            len_q   <= '0;
            opc_q   <= '0;
            rw_q    <= 1'b0;
            bad_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else if (bus_valid && bus_ready) begin
            case (state)
                S_HDR: begin
                    match_q <= (bus_data[7:4] == MY_ID);
                    len_q   <= LEN_W'(bus_data[3:0]);
                    cnt_q   <= '0;
                end
                S_OPC: begin
                    opc_q <= dec;
                    rw_q  <= (dec == 4'd1);
                    bad_q <= (dec == OPC_INVALID);
                end
                S_ADDR: begin
                    addr_q <= ADDR_W'({addr_q, bus_data});
                    cnt_q  <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    assign cmd_valid = !empty && !busy;
    assign pop       = cmd_valid && cmd_ready;

    // FIFO storage; contents need no reset since outputs are gated by empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= '{opc: opc_q, rw: rw_q, len: len_q, addr: addr_q};
    end

    // FIFO pointers, wrapping modulo 2*DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Head presentation; zero while the FIFO is empty
    always_comb begin
        fsm_opcode         = '0;
        read_write         = 1'b0;
        transaction_length = '0;
        cmd_addr           = '0;
        if (!empty) begin
            fsm_opcode         = head.opc;
            read_write         = head.rw;
            transaction_length = head.len;
            cmd_addr           = head.addr;
        end
    end

    // Single outstanding command tracking
    always_ff @(posedge clk) begin
        if (rst)                          busy <= 1'b0;
        else if (pop)                     busy <= 1'b1;
        else if (transaction_done && busy) busy <= 1'b0;
    end

`ifdef CMDP_NACK_EN
    logic nack_req;
    assign nack_req = nack_pend ||
                      ((state == S_ADDR) && bus_valid && addr_last && match_q && bad_q);

    // Acknowledge: done-ack has priority, a colliding nack waits one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_valid <= 1'b0;
            ack_ok    <= 1'b0;
            nack_pend <= 1'b0;
        end else if (transaction_done && busy) begin
            ack_valid <= 1'b1;
            ack_ok    <= 1'b1;
            nack_pend <= nack_req;
        end else if (nack_req) begin
            ack_valid <= 1'b1;
            ack_ok    <= 1'b0;
            nack_pend <= 1'b0;
        end else begin
            ack_valid <= 1'b0;
            ack_ok    <= 1'b0;
        end
    end
`else
    assign nack_pend = 1'b0;

    // Acknowledge completed commands only
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_valid <= 1'b0;
            ack_ok    <= 1'b0;
        end else begin
            ack_valid <= transaction_done && busy;
            ack_ok    <= transaction_done && busy;
        end
    end
`endif

endmodule

// File: tb/tb_cmd_port_queue.sv
// Self-checking bench for cmd_port_queue: a frame/queue-level reference
// model is compared against the DUT every cycle, plus literal expectations
// at key points of the directed sequence.
module tb_cmd_port_queue;
    localparam logic [3:0] MY_ID  = 4'h2;
    localparam int         ADDR_W = 24;
    localparam int         DEPTH  = 4;
    localparam int         LEN_W  = 4;
    localparam int         AB     = ADDR_W / 8;
`ifdef CMDP_NACK_EN
    localparam bit NACK = 1'b1;
`else
    localparam bit NACK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bus_valid = 1'b0;
    logic [7:0]        bus_data = 8'h00;
    logic              bus_ready;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [3:0]        fsm_opcode;
    logic              read_write;
    logic [LEN_W-1:0]  transaction_length;
    logic [ADDR_W-1:0] cmd_addr;
    logic              transaction_done = 1'b0;
    logic              ack_valid;
    logic              ack_ok;

    cmd_port_queue #(.MY_ID(MY_ID), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .bus_valid(bus_valid), .bus_data(bus_data), .bus_ready(bus_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .fsm_opcode(fsm_opcode), .read_write(read_write),
        .transaction_length(transaction_length), .cmd_addr(cmd_addr),
        .transaction_done(transaction_done),
        .ack_valid(ack_valid), .ack_ok(ack_ok)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]        opc;
        logic              rw;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } ent_t;

    ent_t              m_q[$];
    ent_t              m_cur = '0;
    ent_t              c_head;
    int                m_pos = 0;
    bit                m_push = 0, m_bad = 0, m_busy = 0;
    bit                m_ack_v = 0, m_ack_ok = 0, m_nack = 0;
    bit                m_full, m_pop, m_dok, m_nnew, m_nwas;
    logic [3:0]        f_id = '0, f_len = '0, f_code;
    logic [7:0]        f_op = '0;
    logic [ADDR_W-1:0] f_addr = '0;

    function automatic logic [3:0] spec_code(input logic [7:0] op);
        case (op)
            8'h02: return 4'd0;
            8'h03: return 4'd1;
            8'h20: return 4'd2;
            8'h52: return 4'd3;
            8'hD8: return 4'd4;
            8'h99: return 4'd5;
            default: return 4'hF;
        endcase
    endfunction

    // Model advances on each rising edge from the inputs held during the cycle
    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_pos = 0; m_push = 0; m_bad = 0; m_busy = 0;
            m_ack_v = 0; m_ack_ok = 0; m_nack = 0;
        end else begin
            m_full = (m_q.size() == DEPTH);
            m_pop  = (m_q.size() != 0) && !m_busy && cmd_ready;
            m_dok  = transaction_done && m_busy;
            m_nwas = m_nack;
            m_nnew = 0;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_bad) begin
                    if (!m_nwas) m_push = 0;
                end else if (!m_full) begin
                    m_q.push_back(m_cur);
                    m_push = 0;
                end
            end else if (bus_valid) begin
                if (m_pos == 0) begin
                    f_id = bus_data[7:4]; f_len = bus_data[3:0]; m_pos = 1;
                end else if (m_pos == 1) begin
                    f_op = bus_data; m_pos = 2;
                end else begin
                    f_addr = (f_addr << 8) | ADDR_W'(bus_data);
                    if (m_pos == AB + 1) begin
                        m_pos  = 0;
                        f_code = spec_code(f_op);
                        if (f_id == MY_ID) begin
                            if (f_code != 4'hF) begin
                                m_cur  = '{opc: f_code, rw: (f_code == 4'd1), len: f_len, addr: f_addr};
                                m_push = 1; m_bad = 0;
                            end else if (NACK) begin
                                m_push = 1; m_bad = 1; m_nnew = 1;
                            end
                        end
                    end else m_pos++;
                end
            end
            if (m_pop) m_busy = 1;
            else if (m_dok) m_busy = 0;
            if (NACK) begin
                if (m_dok) begin
                    m_ack_v = 1; m_ack_ok = 1; m_nack = m_nnew || m_nwas;
                end else if (m_nnew || m_nwas) begin
                    m_ack_v = 1; m_ack_ok = 0; m_nack = 0;
                end else begin
                    m_ack_v = 0; m_ack_ok = 0;
                end
            end else begin
                m_ack_v = m_dok; m_ack_ok = m_dok;
            end
        end
    end

    // Per-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            c_head = (m_q.size() != 0) ? m_q[0] : '0;
            check("bus_ready", bus_ready, !m_push);
            check("cmd_valid", cmd_valid, (m_q.size() != 0) && !m_busy);
            check("head", {fsm_opcode, read_write, transaction_length, cmd_addr}, c_head);
            check("ack_valid", ack_valid, m_ack_v);
            check("ack_ok", ack_ok, m_ack_ok);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int n;
        acc = 0; n = 0;
        bus_valid = 1'b1; bus_data = b;
        do begin
            acc = bus_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 40);
        if (!acc) check("bus_accept_timeout", 0, 1);
        bus_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [7:0] op, input logic [ADDR_W-1:0] a);
        send_byte(hdr);
        send_byte(op);
        for (int i = AB - 1; i >= 0; i--) send_byte(a[i*8 +: 8]);
    endtask

    task automatic wait_cv();
        int n;
        n = 0;
        while (!cmd_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("cmd_valid_wait", cmd_valid, 1);
    endtask

    task automatic pulse_ready();
        cmd_ready = 1'b1; @(posedge clk); #1; cmd_ready = 1'b0;
    endtask

    task automatic pulse_done();
        transaction_done = 1'b1; @(posedge clk); #1; transaction_done = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        // reset values
        check("rst_bus_ready", bus_ready, 1);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_ack", {ack_valid, ack_ok}, 2'b00);
        check("rst_head", {fsm_opcode, read_write, transaction_length, cmd_addr}, 33'h0);

        // basic read frame
        send_frame(8'h23, 8'h03, 24'h010203);
        check("push_bubble_ready", bus_ready, 0);
        check("push_bubble_cv", cmd_valid, 0);
        idle(1);
        check("rd_cmd_valid", cmd_valid, 1);
        check("rd_opcode", fsm_opcode, 1);
        check("rd_rw", read_write, 1);
        check("rd_len", transaction_length, 3);
        check("rd_addr", cmd_addr, 24'h010203);
        pulse_ready();
        check("busy_cv", cmd_valid, 0);
        idle(2);
        pulse_done();
        check("done_ack", {ack_valid, ack_ok}, 2'b11);
        idle(1);
        check("done_ack_once", ack_valid, 0);

        // other destination: consumed, ignored
        send_frame(8'h53, 8'h02, 24'hAABBCC);
        idle(2);
        check("other_id_cv", cmd_valid, 0);
        check("other_id_ack", ack_valid, 0);

        // fill FIFO and stall fifth frame
        for (int i = 1; i <= 5; i++)
            send_frame({4'h2, 4'(i)}, 8'h02, {8'h10, 8'(i), 8'h00});
        idle(3);
        check("full_stall_ready", bus_ready, 0);
        check("full_head_len", transaction_length, 1);
        pulse_ready();
        idle(1);
        check("stall_release_ready", bus_ready, 1);
        pulse_done();
        check("fill_done_ack", {ack_valid, ack_ok}, 2'b11);
        for (int i = 2; i <= 5; i++) begin
            wait_cv();
            check("order_len", transaction_length, i);
            check("order_addr", cmd_addr, {8'h10, 8'(i), 8'h00});
            pulse_ready();
            pulse_done();
        end
        idle(1);
        check("drained_cv", cmd_valid, 0);

        // invalid opcode to MY_ID
        send_frame(8'h21, 8'hAB, 24'h000000);
        check("bad_op_ack_v", ack_valid, NACK);
        check("bad_op_ack_ok", ack_ok, 0);
        idle(2);
        check("bad_op_no_push", cmd_valid, 0);

        // nack colliding with transaction_done
        send_frame(8'h21, 8'h20, 24'h00F000);
        wait_cv();
        check("erase_opc", fsm_opcode, 2);
        pulse_ready();
        send_byte(8'h21);
        send_byte(8'hAB);
        for (int i = 0; i < AB - 1; i++) send_byte(8'h00);
        bus_valid = 1'b1; bus_data = 8'h00; transaction_done = 1'b1;
        @(posedge clk); #1;
        bus_valid = 1'b0; transaction_done = 1'b0;
        check("coll_ok_first", {ack_valid, ack_ok}, 2'b11);
        idle(1);
        check("coll_nack_next", {ack_valid, ack_ok}, {NACK, 1'b0});
        idle(1);
        check("coll_quiet", ack_valid, 0);

        // reset mid-frame with entries queued
        send_frame(8'h21, 8'h52, 24'h111111);
        send_frame(8'h22, 8'hD8, 24'h222222);
        send_byte(8'h23); send_byte(8'h03); send_byte(8'h44);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        check("mid_rst_cv", cmd_valid, 0);
        check("mid_rst_ready", bus_ready, 1);
        check("mid_rst_head", {fsm_opcode, read_write, transaction_length, cmd_addr}, 33'h0);
        send_frame(8'h21, 8'h99, 24'h000000);
        idle(1);
        check("dp_cv", cmd_valid, 1);
        check("dp_opcode", fsm_opcode, 5);
        check("dp_rw", read_write, 0);

        // done while idle is ignored
        pulse_done();
        check("idle_done_no_ack", ack_valid, 0);
        idle(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
